// File: rtl/spram_dma.sv
// spram_dma: block fill/dump DMA engine driving the spram port with a wrapping address pointer.
// Define SPRAM_DMA_ARB_EN to gate every RAM access with the arbiter grant gnt.
module spram_dma #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  start,
  input  logic                  dir,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  input  logic                  gnt,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_we,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_dout
);
  typedef enum logic [1:0] {IDLE, FILL, DUMP, FIN} state_t;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]     rem_q, rem_d, snk_q, snk_d;
  logic [DATA_WIDTH-1:0]   head_q, head_d, tail_q, tail_d;
  logic [1:0]              occ_q, occ_d;
  logic                    inf_q, inf_d;
  logic                    ok, wr, pop;
`ifdef SPRAM_DMA_ARB_EN
  assign ok = gnt;
`else
  assign ok = gnt | 1'b1;
`endif
  always_comb begin
    busy     = (state_q == FILL) || (state_q == DUMP);
    done     = state_q == FIN;
    s_ready  = (state_q == FILL) && ok;
    wr       = s_valid && s_ready;
    ram_we   = wr;
    ram_din  = s_data;
    ram_addr = ptr_q;
    m_valid  = occ_q != 2'd0;
    m_data   = head_q;
    pop      = m_valid && m_ready;
    // the entry popped this cycle frees a slot, which keeps a 2-deep buffer at full rate
    ram_re   = (state_q == DUMP) && ok && (rem_q != '0) && ((occ_q + 2'(inf_q) - 2'(pop)) < 2'd2);
    inf_d    = ram_re;
    occ_d    = occ_q + 2'(inf_q) - 2'(pop);
    head_d   = pop ? ((occ_q == 2'd2) ? tail_q : ram_dout) : ((inf_q && occ_q == 2'd0) ? ram_dout : head_q);
    tail_d   = (inf_q && ((occ_q == 2'd2 && pop) || (occ_q == 2'd1 && !pop))) ? ram_dout : tail_q;
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    snk_d    = snk_q;
    case (state_q)
      IDLE: if (start) begin
        ptr_d   = base;
        rem_d   = len;
        snk_d   = len;
        state_d = (len == '0) ? FIN : (dir ? DUMP : FILL);
      end
      FILL: if (wr) begin
        ptr_d   = ptr_q + PTR_ONE;
        rem_d   = rem_q - CNT_ONE;
        state_d = (rem_q == CNT_ONE) ? FIN : FILL;
      end
      DUMP: begin
        ptr_d   = ram_re ? ptr_q + PTR_ONE : ptr_q;
        rem_d   = ram_re ? rem_q - CNT_ONE : rem_q;
        snk_d   = pop ? snk_q - CNT_ONE : snk_q;
        state_d = (pop && snk_q == CNT_ONE) ? FIN : DUMP;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      snk_q   <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      inf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      snk_q   <= snk_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      occ_q   <= occ_d;
      inf_q   <= inf_d;
    end
  end
endmodule
